conv_mac_1: RTL and testbench

Multiply-accumulate stage of convolution layer 1: sits directly downstream of the layer-1 weight streamer and consumes its coefficient stream together with the layer-1 pixel stream. For every `KERN_SIZE` (pixel, weight) pairs it produces one fixed-point output sample: accumulated, rescaled and saturated. All three streams use the codebase's FIFO handshake, so the block drops between HLS-generated FIFOs without adapters.

---
 rtl/conv_mac_1_pkg.sv | 26 ++
 rtl/conv_mac_1_requant.sv | 38 +++
 rtl/conv_mac_1.sv | 103 ++++++++++
 tb/tb_conv_mac_1.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_1_pkg.sv
// Layer-1 convolution constants, MAC state encoding and width helpers.
package conv_mac_1_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        EMIT = 1'b1
    } state_e;

    localparam int unsigned L1_KERN_SIZE = 9;
    localparam int unsigned L1_COEFF_W   = 16;
    localparam int unsigned L1_PIX_W     = 16;
    localparam int unsigned L1_OUT_W     = 16;
    localparam int unsigned L1_FRAC_BITS = 8;

    // Wide enough that KERN_SIZE full-scale products can never overflow.
    function automatic int unsigned acc_width(input int unsigned pix_w,
                                              input int unsigned coeff_w,
                                              input int unsigned kern);
        return pix_w + coeff_w + $clog2(kern);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned kern);
        return (kern > 1) ? $clog2(kern) : 1;
    endfunction

endpackage

// File: rtl/conv_mac_1_requant.sv
// Layer-1 requantiser: arithmetic shift, saturate to OUT_W, optional ReLU.
// Macro CONV_1_RELU_EN clamps negative results to zero.
module conv_1_requant
    import conv_mac_1_pkg::*;
#(
    parameter int unsigned ACC_W     = acc_width(L1_PIX_W, L1_COEFF_W, L1_KERN_SIZE),
    parameter int unsigned OUT_W     = L1_OUT_W,
    parameter int unsigned FRAC_BITS = L1_FRAC_BITS
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] dout_o
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;
    logic signed [OUT_W-1:0] sat;

    always_comb begin
        shifted = acc_i >>> FRAC_BITS;
        if (shifted > MAX_V) begin
            sat = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted < MIN_V) begin
            sat = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat = shifted[OUT_W-1:0];
        end
`ifdef CONV_1_RELU_EN
        if (sat[OUT_W-1]) begin
            sat = '0;
        end
`else
`endif
        dout_o = sat;
    end

endmodule

// File: rtl/conv_mac_1.sv
// Layer-1 multiply-accumulate stage between FIFO-handshake pixel/weight streams and output FIFO.
// Macro CONV_1_RELU_EN enables ReLU on the emitted sample (see conv_1_requant).
module conv_mac_1
    import conv_mac_1_pkg::*;
#(
    parameter int unsigned KERN_SIZE = L1_KERN_SIZE,
    parameter int unsigned COEFF_W   = L1_COEFF_W,
    parameter int unsigned PIX_W     = L1_PIX_W,
    parameter int unsigned OUT_W     = L1_OUT_W,
    parameter int unsigned FRAC_BITS = L1_FRAC_BITS
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [PIX_W-1:0]   input_V_dout,
    input  logic               input_V_empty_n,
    output logic               input_V_read,
    input  logic [COEFF_W-1:0] weight_V_dout,
    input  logic               weight_V_empty_n,
    output logic               weight_V_read,
    output logic [OUT_W-1:0]   output_V_din,
    input  logic               output_V_full_n,
    output logic               output_V_write
);

    localparam int unsigned ACC_W  = acc_width(PIX_W, COEFF_W, KERN_SIZE);
    localparam int unsigned CNT_W  = cnt_width(KERN_SIZE);
    localparam int unsigned PROD_W = PIX_W + COEFF_W;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(KERN_SIZE - 1);

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [OUT_W-1:0]   dout_q, dout_d, req_out;
    logic signed [PROD_W-1:0]  prod;
    logic                      fire;

    assign prod    = $signed(input_V_dout) * $signed(weight_V_dout);
    assign acc_sum = acc_q + ACC_W'(prod);

    // The final tap's sum is requantised on the fly and registered, so the
    // emitted sample is stable for the whole EMIT state.
    conv_1_requant #(
        .ACC_W     (ACC_W),
        .OUT_W     (OUT_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_requant (
        .acc_i  (acc_sum),
        .dout_o (req_out)
    );

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        dout_d         = dout_q;
        fire           = 1'b0;
        input_V_read   = 1'b0;
        weight_V_read  = 1'b0;
        output_V_write = 1'b0;
        case (state_q)
            ACC: begin
                fire          = input_V_empty_n & weight_V_empty_n;
                input_V_read  = fire;
                weight_V_read = fire;
                if (fire) begin
                    if (cnt_q == LAST_TAP) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        dout_d  = req_out;
                        state_d = EMIT;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                output_V_write = output_V_full_n;
                if (output_V_full_n) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign output_V_din = dout_q;

endmodule

// File: tb/tb_conv_mac_1.sv
// Directed bench for conv_mac_1 (defaults: 9 taps, 16-bit, FRAC_BITS=8); honours CONV_1_RELU_EN.
module tb_conv_mac_1;

`ifdef CONV_1_RELU_EN
    localparam int RELU = 1;
`else
    localparam int RELU = 0;
`endif

    logic               ap_clk;
    logic               ap_rst_n;
    logic [15:0]        input_V_dout;
    logic               input_V_empty_n;
    logic               input_V_read;
    logic [15:0]        weight_V_dout;
    logic               weight_V_empty_n;
    logic               weight_V_read;
    logic signed [15:0] output_V_din;
    logic               output_V_full_n;
    logic               output_V_write;

    int n_checks = 0;
    int n_pass   = 0;

    conv_mac_1 #(
        .KERN_SIZE (9),
        .COEFF_W   (16),
        .PIX_W     (16),
        .OUT_W     (16),
        .FRAC_BITS (8)
    ) dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .input_V_dout     (input_V_dout),
        .input_V_empty_n  (input_V_empty_n),
        .input_V_read     (input_V_read),
        .weight_V_dout    (weight_V_dout),
        .weight_V_empty_n (weight_V_empty_n),
        .weight_V_read    (weight_V_read),
        .output_V_din     (output_V_din),
        .output_V_full_n  (output_V_full_n),
        .output_V_write   (output_V_write)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    function automatic int relu(input int x);
        return (RELU != 0 && x < 0) ? 0 : x;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic pop_pair(input int p, input int w, input string tag);
        input_V_dout     = p[15:0];
        weight_V_dout    = w[15:0];
        input_V_empty_n  = 1'b1;
        weight_V_empty_n = 1'b1;
        #1;
        check({tag, "_rd"}, int'({input_V_read, weight_V_read}), 3);
        check({tag, "_wr"}, int'(output_V_write), 0);
        tick();
    endtask

    task automatic expect_emit(input int exp, input string tag);
        input_V_empty_n  = 1'b1;
        weight_V_empty_n = 1'b1;
        output_V_full_n  = 1'b1;
        #1;
        check({tag, "_wr"}, int'(output_V_write), 1);
        check({tag, "_din"}, int'(output_V_din), exp);
        check({tag, "_rd"}, int'({input_V_read, weight_V_read}), 0);
        input_V_empty_n  = 1'b0;
        weight_V_empty_n = 1'b0;
        tick();
    endtask

    initial begin
        ap_rst_n         = 1'b0;
        input_V_dout     = '0;
        weight_V_dout    = '0;
        input_V_empty_n  = 1'b0;
        weight_V_empty_n = 1'b0;
        output_V_full_n  = 1'b0;
        repeat (3) tick();
        #1;
        check("rst_rd", int'({input_V_read, weight_V_read}), 0);
        check("rst_wr", int'(output_V_write), 0);
        check("rst_din", int'(output_V_din), 0);
        ap_rst_n = 1'b1;
        tick();

        // 9 x 256*256 = 589824, >>>8 = 2304
        for (int i = 0; i < 9; i++) pop_pair(256, 256, "basic");
        expect_emit(2304, "basic");

        // 4 taps, then each stream alone with junk data, then 5 more taps: 9 x -1536 >>> 8 = -54
        for (int i = 0; i < 4; i++) pop_pair(-3, 512, "unbal");
        input_V_dout  = 16'd7777;
        weight_V_dout = 16'd9999;
        for (int i = 0; i < 3; i++) begin
            input_V_empty_n = 1'b1; weight_V_empty_n = 1'b0;
            #1; check("unbal_pixonly_rd", int'({input_V_read, weight_V_read}), 0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            input_V_empty_n = 1'b0; weight_V_empty_n = 1'b1;
            #1; check("unbal_wgtonly_rd", int'({input_V_read, weight_V_read}), 0);
            tick();
        end
        for (int i = 0; i < 5; i++) pop_pair(-3, 512, "unbal");
        expect_emit(relu(-54), "unbal");

        // pixels 1..9 x 256 -> 45, then 5 stalled cycles
        for (int i = 0; i < 9; i++) pop_pair(i + 1, 256, "bp");
        for (int i = 0; i < 5; i++) begin
            output_V_full_n = 1'b0; input_V_empty_n = 1'b1; weight_V_empty_n = 1'b1;
            #1;
            check("bp_stall_wr", int'(output_V_write), 0);
            check("bp_stall_rd", int'({input_V_read, weight_V_read}), 0);
            check("bp_stall_din", int'(output_V_din), 45);
            tick();
        end
        expect_emit(45, "bp");

        for (int i = 0; i < 9; i++) pop_pair(32767, 32767, "satp");
        expect_emit(32767, "satp");
        for (int i = 0; i < 9; i++) pop_pair(-32768, 32767, "satn");
        expect_emit(relu(-32768), "satn");

        // Reset after 4 large taps; only the following 9 x (1,256) count -> 9
        for (int i = 0; i < 4; i++) pop_pair(1000, 1000, "rstmid");
        ap_rst_n = 1'b0; input_V_empty_n = 1'b0; weight_V_empty_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        for (int i = 0; i < 9; i++) pop_pair(1, 256, "rstmid");
        expect_emit(9, "rstmid");

        // Reset while a result is pending drops it
        for (int i = 0; i < 9; i++) pop_pair(256, 256, "rstemit");
        output_V_full_n = 1'b0; input_V_empty_n = 1'b0; weight_V_empty_n = 1'b0;
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        output_V_full_n = 1'b1;
        #1;
        check("rstemit_wr", int'(output_V_write), 0);
        check("rstemit_din", int'(output_V_din), 0);
        tick();

        // Streaming: kernel k uses pixels t+k, weight 256 -> 36+9k; 10 cycles per kernel
        output_V_full_n  = 1'b1;
        input_V_empty_n  = 1'b1;
        weight_V_empty_n = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            input_V_dout  = 16'((cyc % 10) + (cyc / 10));
            weight_V_dout = 16'd256;
            #1;
            if ((cyc % 10) < 9) begin
                check("stream_rd", int'({input_V_read, weight_V_read}), 3);
                check("stream_wr", int'(output_V_write), 0);
            end else begin
                check("stream_rd_emit", int'({input_V_read, weight_V_read}), 0);
                check("stream_wr", int'(output_V_write), 1);
                check("stream_din", int'(output_V_din), 36 + 9 * (cyc / 10));
            end
            tick();
        end
        input_V_empty_n  = 1'b0;
        weight_V_empty_n = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
